// File: rtl/imageproc_pkg.sv
// Shared types for the imageproc command path: sequencer state encoding and the
// command/operand pair carried through the sequencer FIFO.
package imageproc_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        EXEC,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/imageproc_cmd_sequencer_if.sv
// Command handshake between the sequencer (master) and imageproc (slave).
interface imageproc_cmd_sequencer_if #(
    parameter int unsigned CMD_W  = imageproc_pkg::CMD_W,
    parameter int unsigned DATA_W = imageproc_pkg::DATA_W
);
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_valid;
    logic              cmd_ack;
    logic              busy;
    logic              refresh;
    logic              error;

    modport master (
        output cmd, cmd_data, cmd_valid,
        input  cmd_ack, busy, refresh, error
    );

    modport slave (
        input  cmd, cmd_data, cmd_valid,
        output cmd_ack, busy, refresh, error
    );
endinterface

// File: rtl/imageproc_cmd_fifo.sv
// Synchronous FIFO of command entries; push while full and pop while empty are ignored.
module imageproc_cmd_fifo
    import imageproc_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type entry_t = cmd_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/imageproc_cmd_sequencer.sv
// Feeds buffered host commands to imageproc one at a time, with ack/busy timeouts,
// bounded retry on error, sticky status flags and completion/refresh counters.
module imageproc_cmd_sequencer #(
    parameter int unsigned CMD_W     = imageproc_pkg::CMD_W,
    parameter int unsigned DATA_W    = imageproc_pkg::DATA_W,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CMD_W-1:0]       in_cmd,
    input  logic [DATA_W-1:0]      in_data,
    imageproc_cmd_sequencer_if.master proc_bus,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            done_count,
    output logic [15:0]            refresh_count,
    output logic                   err_flag,
    output logic                   timeout_flag
);
    import imageproc_pkg::*;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } entry_t;

    seq_state_e         state;
    entry_t             fifo_head;
    entry_t             fifo_in;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [TW-1:0]      timer;
    logic [RW-1:0]      retry_cnt;
    logic [CMD_W-1:0]   hold_cmd;
    logic [DATA_W-1:0]  hold_data;
    logic               cmd_valid_r;

    assign fifo_in  = '{cmd: in_cmd, data: in_data};
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign in_ready = !fifo_full;

    assign proc_bus.cmd       = hold_cmd;
    assign proc_bus.cmd_data  = hold_data;
    assign proc_bus.cmd_valid = cmd_valid_r;

    imageproc_cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (fifo_in),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // clear is applied first so a same-cycle set/increment further down overrides it
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold_cmd     <= '0;
            hold_data    <= '0;
            cmd_valid_r  <= 1'b0;
            timer        <= '0;
            retry_cnt    <= '0;
            done_count   <= '0;
            err_flag     <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (clear) begin
                done_count   <= '0;
                err_flag     <= 1'b0;
                timeout_flag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        hold_cmd    <= fifo_head.cmd;
                        hold_data   <= fifo_head.data;
                        cmd_valid_r <= 1'b1;
                        retry_cnt   <= '0;
                        timer       <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (proc_bus.cmd_ack) begin
                        cmd_valid_r <= 1'b0;
                        timer       <= '0;
                        state       <= EXEC;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        cmd_valid_r  <= 1'b0;
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                EXEC: begin
                    if (proc_bus.error) begin
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt   <= retry_cnt + RW'(1);
                            cmd_valid_r <= 1'b1;
                            timer       <= '0;
                            state       <= ISSUE;
                        end else begin
                            err_flag <= 1'b1;
                            state    <= IDLE;
                        end
                    end else if (!proc_bus.busy) begin
                        state <= DONE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    done_count <= clear ? 16'd1 : done_count + 16'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_count <= '0;
        end else if (proc_bus.refresh) begin
            refresh_count <= clear ? 16'd1 : refresh_count + 16'd1;
        end else if (clear) begin
            refresh_count <= '0;
        end
    end

endmodule

// File: doc/imageproc_cmd_sequencer.md
Name: imageproc_cmd_sequencer

Overview:
- Upstream command source for imageproc.
- Buffers host commands in a FIFO and drives imageproc's cmd/cmd_data/cmd_valid/cmd_ack handshake one command at a time.
- Waits for each command to finish, using busy, before issuing the next.
- Retries commands that end in error and enforces timeouts; reports sticky status and completion counts to the host/testbench.

Parameters:
- CMD_W, 4: width of cmd opcode.
- DATA_W, 16: width of cmd_data.
- DEPTH, 8: FIFO entries; power of 2, at least 2.
- TIMEOUT, 255: cycles allowed waiting for cmd_ack, or for busy to drop.
- MAX_RETRY, 2: re-issues allowed after error before the command is dropped.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- in_valid  in  1  host command valid
- in_ready  out  1  FIFO can accept
- in_cmd  in  CMD_W  host opcode
- in_data  in  DATA_W  host operand
- cmd  out  CMD_W  opcode to imageproc
- cmd_data  out  DATA_W  operand to imageproc
- cmd_valid  out  1  command offered to imageproc
- cmd_ack  in  1  imageproc accepted command
- busy  in  1  imageproc executing
- refresh  in  1  imageproc refresh pulse
- error  in  1  imageproc error indication
- fifo_level  out  $clog2(DEPTH)+1  entries held
- done_count  out  16  commands completed without error; wraps at 65535
- refresh_count  out  16  refresh pulses seen; wraps
- err_flag  out  1  sticky: command dropped after retries
- timeout_flag  out  1  sticky: timeout occurred
- clear  in  1  clears sticky flags and both counters

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
  - rst sampled high on a clk rising edge: FIFO emptied, FSM to IDLE, all counters and flags 0.
  - Reset outputs: cmd_valid=0, cmd=0, cmd_data=0, fifo_level=0, in_ready=1.
  - Reset mid-handshake abandons the command with no further cmd_valid.
- Push: in_valid && in_ready writes the FIFO.
  - in_ready = !full, combinational from the registered level.
  - A push and a pop in the same cycle leave the level unchanged. With a full FIFO the push is still refused that cycle (no bypass).
- FSM states: IDLE, ISSUE, EXEC, DONE.
- IDLE, FIFO non-empty: pop head into hold register; retry_cnt=0; next state ISSUE. cmd_valid rises the cycle after the pop (registered).
- ISSUE: cmd_valid=1, cmd/cmd_data held stable until acknowledged.
  - On cmd_ack sampled high: cmd_valid drops the next cycle; next state EXEC.
  - If TIMEOUT cycles pass without ack: timeout_flag set, command dropped, next state IDLE.
- EXEC: timer restarts on entry.
  - error high in any EXEC cycle: if retry_cnt<MAX_RETRY, increment retry_cnt and go to ISSUE (same command re-offered). Otherwise set err_flag, drop the command, go to IDLE.
  - busy==0 and error==0 in any EXEC cycle: go to DONE. This includes the first EXEC cycle, so a command that never raises busy completes.
  - busy high for TIMEOUT cycles: timeout_flag set, go to IDLE.
  - error takes priority over completion in the same cycle.
- DONE: increment done_count; go to IDLE. Minimum spacing between cmd_valid pulses is 3 idle-output cycles.
- refresh_count increments on every cycle with refresh high, in any state.
- clear: zeros done_count, refresh_count, err_flag, timeout_flag. If a set/increment coincides with clear, the set/increment wins (flag=1, counter=1).
- Counters wrap 65535->0 silently.
- The FIFO pointer is $clog2(DEPTH) bits with natural wrap; the level is one bit wider to distinguish full from empty.

Decomposition:
- Package imageproc_pkg holds:
  - the seq_state_e enum {IDLE, ISSUE, EXEC, DONE};
  - the cmd_t struct {cmd, data};
  - default CMD_W/DATA_W localparams shared with imageproc.
- One sub-module, imageproc_cmd_fifo: synchronous FIFO of cmd_t, DEPTH entries, push/pop/full/empty/level.

Test Plan:
- Reset with rst=1 for 2 cycles while pushing -> all outputs 0, in_ready=1, no write occurs.
- Push 3 commands (cmd=1,2,3; data=0x0010,0x0020,0x0030); ack after 1 cycle, busy high 4 cycles -> issued in order, cmd stable while cmd_valid=1, done_count=3, fifo_level back to 0.
- Push 9 commands with cmd_ack tied 0 -> in_ready=0 once level is 8 (first command held in hold register). After 255 cycles: timeout_flag=1, next command issued.
- Error asserted in EXEC on every attempt -> same command offered 3 times total, then err_flag=1, done_count unchanged, next command proceeds.
- Error on the first attempt only -> 2 offers, done_count+1, err_flag=0.
- Drive refresh 5 pulses, then clear in the same cycle as a DONE -> refresh_count=0, done_count=1, flags=0.
